// File: rtl/syscall_pkg.sv
// Shared definitions for the syscall responder: service codes, register
// indices and the responder state encoding.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_EXIT      = 32'd10;

  // Register file indices the syscall ABI uses ($v0 result/code, $a0 argument).
  localparam logic [4:0] V0_REG = 5'd2;
  localparam logic [4:0] A0_REG = 5'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRINT_INT = 3'd1,
    ST_PRINT_STR = 3'd2,
    ST_READ_INT  = 3'd3,
    ST_DONE      = 3'd4,
    ST_HALT      = 3'd5
  } syscall_state_e;

endpackage

// File: rtl/byte_lane_select.sv
// Picks one byte out of a memory word, little-endian: lane 0 is word[7:0].
module byte_lane_select #(
  parameter int W = 32
) (
  input  logic [W-1:0] word,
  input  logic [1:0]   lane,
  output logic [7:0]   sel_byte
);

  // Lane index scales to a bit offset of 8*lane.
  always_comb begin
    sel_byte = word[8*lane +: 8];
  end

endmodule

// File: rtl/syscall_responder.sv
// Services processor syscalls: print integer, print string (walks memory
// through the syscall address mux), read integer and exit. The core is
// stalled for the whole service and completes the instruction in DONE.
//
// Stream handshakes: an item moves on a rising edge where valid && ready are
// both high. While valid is high and ready is low, the producer holds valid
// and data stable; the consumer may raise ready at any time.
module syscall_responder
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 1024,
  parameter int DATA_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sys_enable,
  input  logic [DATA_W-1:0] v0,
  input  logic [DATA_W-1:0] a0,
  output logic              stall,
  output logic              sys_mem,
  output logic [DATA_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              sys_regwrite,
  output logic [DATA_W-1:0] sys_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_is_int,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              halted,
  output syscall_state_e    state_dbg
);

  localparam int CNT_W = $clog2(MAX_STR_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_STR_LEN - 1);

  syscall_state_e    state;
  logic [DATA_W-1:0] ptr;        // string walk pointer (byte address)
  logic [DATA_W-1:0] val;        // print-int argument or read-int result
  logic [CNT_W-1:0]  count;      // bytes emitted by the current print-string
  logic              wr_result;  // DONE must write val back to $v0
  logic [7:0]        cur_byte;
  logic              str_valid;

  byte_lane_select #(.W(DATA_W)) u_lane (
    .word     (mem_data),
    .lane     (ptr[1:0]),
    .sel_byte (cur_byte)
  );

  // Service FSM: decode in IDLE, run the service, one DONE cycle, back to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      val       <= '0;
      count     <= '0;
      wr_result <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sys_enable) begin
            ptr       <= a0;
            val       <= a0;
            count     <= '0;
            wr_result <= 1'b0;
            case (v0)
              DATA_W'(SYS_PRINT_INT): state <= ST_PRINT_INT;
              DATA_W'(SYS_PRINT_STR): state <= ST_PRINT_STR;
              DATA_W'(SYS_READ_INT):  state <= ST_READ_INT;
              DATA_W'(SYS_EXIT):      state <= ST_HALT;
              default:                state <= ST_DONE;
            endcase
          end
        end
        ST_PRINT_INT: begin
          if (out_ready) state <= ST_DONE;
        end
        ST_PRINT_STR: begin
          if (cur_byte == 8'd0) begin
            state <= ST_DONE;
          end else if (out_ready) begin
            ptr   <= ptr + 1'b1;
            count <= count + 1'b1;
            if (count == LAST_CNT) state <= ST_DONE;
          end
        end
        ST_READ_INT: begin
          if (in_valid) begin
            val       <= in_data;
            wr_result <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          wr_result <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode from the registered state; the string byte comes straight
  // from the combinational memory read of sys_addr.
  always_comb begin
    stall        = (state == ST_IDLE && sys_enable) || (state == ST_PRINT_INT) ||
                   (state == ST_PRINT_STR) || (state == ST_READ_INT) ||
                   (state == ST_HALT);
    sys_mem      = (state == ST_PRINT_STR);
    sys_addr     = sys_mem ? {ptr[DATA_W-1:2], 2'b00} : '0;
    str_valid    = sys_mem && (cur_byte != 8'd0);
    out_valid    = (state == ST_PRINT_INT) || str_valid;
    out_is_int   = (state == ST_PRINT_INT);
    out_data     = (state == ST_PRINT_INT) ? val :
                   str_valid ? {{(DATA_W-8){1'b0}}, cur_byte} : '0;
    in_ready     = (state == ST_READ_INT);
    sys_regwrite = (state == ST_DONE) && wr_result;
    sys_data     = sys_regwrite ? val : '0;
    halted       = (state == ST_HALT);
    state_dbg    = state;
  end

endmodule

// File: tb/tb_syscall_responder.sv
// Randomized bench for syscall_responder against a transaction-level model:
// expected console items come from walking a memory array, and the expected
// DONE cycle comes from counting the ready pattern the bench itself drives.
module tb_syscall_responder;
  import syscall_pkg::*;

  localparam int MAX_LEN = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           sys_enable;
  logic [31:0]    v0, a0;
  logic           stall, sys_mem, sys_regwrite;
  logic [31:0]    sys_addr, mem_data, sys_data;
  logic           out_valid, out_ready, out_is_int;
  logic [31:0]    out_data;
  logic           in_valid, in_ready;
  logic [31:0]    in_data;
  logic           halted;
  syscall_state_e state_dbg;

  logic [31:0] mem [0:255];
  assign mem_data = mem[sys_addr[9:2]];

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  bit ready_pat [0:511];

  syscall_responder #(.MAX_STR_LEN(MAX_LEN), .DATA_W(32)) dut (
    .clock(clock), .reset(reset), .sys_enable(sys_enable), .v0(v0), .a0(a0),
    .stall(stall), .sys_mem(sys_mem), .sys_addr(sys_addr), .mem_data(mem_data),
    .sys_regwrite(sys_regwrite), .sys_data(sys_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_is_int(out_is_int), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .halted(halted), .state_dbg(state_dbg)
  );

  // Clock generation
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] addr);
    logic [31:0] w;
    w = mem[addr[9:2]];
    return w[8*addr[1:0] +: 8];
  endfunction

  task automatic set_byte(input logic [31:0] addr, input logic [7:0] b);
    logic [31:0] w;
    w = mem[addr[9:2]];
    w[8*addr[1:0] +: 8] = b;
    mem[addr[9:2]] = w;
  endtask

  // Drive one syscall to completion and score it against the model.
  task automatic run_syscall(input logic [31:0] code, input logic [31:0] arg,
                             input int hold, input int pct, input int in_delay,
                             input logic [31:0] in_val);
    int done_at, cyc, c, n;
    bit nul_end, finished, prev_pend;
    logic [31:0] prev_data, p, a;
    logic [32:0] e;
    logic [7:0] b;

    for (int i = 0; i < 512; i++)
      ready_pat[i] = (i >= 1 && i <= hold) ? 1'b0 : ($urandom_range(0, 99) < pct);

    exp_q.delete();
    exp_addr_q.delete();
    nul_end = 1'b0;
    if (code == SYS_PRINT_INT) begin
      exp_q.push_back({1'b1, arg});
      exp_addr_q.push_back(32'd0);
    end else if (code == SYS_PRINT_STR) begin
      n = 0;
      while (n < MAX_LEN) begin
        p = arg + 32'(n);
        b = get_byte(p);
        if (b == 8'd0) break;
        exp_q.push_back({1'b0, 24'd0, b});
        exp_addr_q.push_back({p[31:2], 2'b00});
        n++;
      end
      nul_end = (n < MAX_LEN);
    end

    if (code == SYS_PRINT_INT || code == SYS_PRINT_STR) begin
      c = 1;
      for (int k = 0; k < exp_q.size(); k++) begin
        while (!ready_pat[c]) c++;
        c++;
      end
      if (nul_end) c++;
      done_at = c;
    end else if (code == SYS_READ_INT) begin
      done_at = in_delay + 1;
    end else begin
      done_at = 1;
    end

    cyc = 0;
    finished = 1'b0;
    prev_pend = 1'b0;
    prev_data = '0;
    while (!finished && cyc < 400) begin
      @(negedge clock);
      if (cyc == 0) begin
        sys_enable = 1'b1;
        v0 = code;
        a0 = arg;
      end
      out_ready = ready_pat[cyc];
      in_valid  = (code == SYS_READ_INT) && (cyc >= in_delay);
      in_data   = in_val;
      #1;
      if (prev_pend) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        check_eq("item_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          a = exp_addr_q.pop_front();
          check_eq("out_is_int", 32'(out_is_int), 32'(e[32]));
          check_eq("out_data", out_data, e[31:0]);
          if (!e[32]) begin
            check_eq("sys_addr", sys_addr, a);
            check_eq("sys_mem", 32'(sys_mem), 32'd1);
          end
        end
      end
      prev_pend = out_valid && !out_ready;
      prev_data = out_data;
      if (!stall) begin
        check_eq("done_cycle", 32'(cyc), 32'(done_at));
        check_eq("done_regwrite", 32'(sys_regwrite), 32'(code == SYS_READ_INT));
        check_eq("done_sys_data", sys_data, (code == SYS_READ_INT) ? in_val : 32'd0);
        check_eq("done_out_valid", 32'(out_valid), 32'd0);
        check_eq("done_sys_mem", 32'(sys_mem), 32'd0);
        check_eq("left_items", 32'(exp_q.size()), 32'd0);
        sys_enable = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        finished   = 1'b1;
      end
      cyc++;
    end
    check_eq("timeout", 32'(finished), 32'd1);
    sys_enable = 1'b0;
    @(negedge clock);
    #1;
    check_eq("idle_after", 32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Main sequence
  initial begin
    logic [31:0] code, arg;
    int len, sel;

    reset = 1'b1; sys_enable = 1'b0; v0 = '0; a0 = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sys_mem", 32'(sys_mem), 32'd0);
    check_eq("rst_regwrite", 32'(sys_regwrite), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;

    // Print-int under three cycles of back-pressure
    run_syscall(SYS_PRINT_INT, 32'hFFFF_FFF9, 3, 100, 0, 32'd0);
    // "\0\0HI" at 0x100 followed by a zero word, walk starts at 0x102
    mem[8'h40] = 32'h4948_0000;
    mem[8'h41] = 32'h0000_0000;
    run_syscall(SYS_PRINT_STR, 32'h0000_0102, 0, 60, 0, 32'd0);
    // Read-int with input arriving on cycle 5
    run_syscall(SYS_READ_INT, 32'd0, 0, 100, 5, 32'd42);
    // Unknown code
    run_syscall(32'd7, 32'h1234_5678, 0, 100, 0, 32'd0);
    // NUL-free string across the address wrap, stopped by the length limit
    set_byte(32'hFFFF_FFFE, 8'h57);
    set_byte(32'hFFFF_FFFF, 8'h58);
    set_byte(32'h0000_0000, 8'h59);
    set_byte(32'h0000_0001, 8'h5A);
    run_syscall(SYS_PRINT_STR, 32'hFFFF_FFFE, 1, 50, 0, 32'd0);

    // Random mix of services
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      arg = $urandom;
      case (sel)
        0: code = SYS_PRINT_INT;
        1: begin
          code = SYS_PRINT_STR;
          arg = {22'd0, 10'($urandom_range(0, 1000))};
          len = $urandom_range(0, 6);
          for (int i = 0; i < len; i++) set_byte(arg + 32'(i), 8'($urandom_range(1, 255)));
          if (len <= MAX_LEN) set_byte(arg + 32'(len), 8'd0);
        end
        2: code = SYS_READ_INT;
        default: begin
          code = $urandom;
          if (code == SYS_PRINT_INT || code == SYS_PRINT_STR ||
              code == SYS_READ_INT || code == SYS_EXIT) code = 32'd7;
        end
      endcase
      run_syscall(code, arg, $urandom_range(0, 2), $urandom_range(30, 100),
                  $urandom_range(1, 6), $urandom);
    end

    // Reset in the middle of a back-pressured print-string
    set_byte(32'h200, 8'h41);
    set_byte(32'h201, 8'h42);
    set_byte(32'h202, 8'h00);
    @(negedge clock);
    sys_enable = 1'b1; v0 = SYS_PRINT_STR; a0 = 32'h200; out_ready = 1'b0;
    @(negedge clock); #1;
    check_eq("mid_str_valid", 32'(out_valid), 32'd1);
    @(negedge clock);
    reset = 1'b1; sys_enable = 1'b0;
    @(negedge clock); #1;
    check_eq("abort_out_valid", 32'(out_valid), 32'd0);
    check_eq("abort_sys_mem", 32'(sys_mem), 32'd0);
    check_eq("abort_regwrite", 32'(sys_regwrite), 32'd0);
    check_eq("abort_stall", 32'(stall), 32'd0);
    reset = 1'b0;

    // Exit is terminal until reset
    @(negedge clock);
    sys_enable = 1'b1; v0 = SYS_EXIT; a0 = 32'd0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_eq("halt_stall", 32'(stall), 32'd1);
      check_eq("halt_flag", 32'(halted), (k == 0) ? 32'd0 : 32'd1);
      @(negedge clock);
    end
    reset = 1'b1; sys_enable = 1'b0;
    @(negedge clock); #1;
    check_eq("unhalt_flag", 32'(halted), 32'd0);
    check_eq("unhalt_stall", 32'(stall), 32'd0);
    check_eq("unhalt_state", 32'(state_dbg), 32'(ST_IDLE));
    reset = 1'b0;

    // Service still works after leaving HALT
    run_syscall(SYS_READ_INT, 32'd0, 0, 100, 2, 32'hCAFE_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
